// File: rtl/output_signature_sink_if.sv
// Bundles the clear/data inputs and the observation outputs of output_signature_sink.
// The master side drives the DUT output bus and clear; the slave side is the sink.
interface output_signature_sink_if #(
   parameter int WIDTH = 32
) ();
   logic             clear;
   logic             valid_in;
   logic [WIDTH-1:0] data_in;
   logic             sig_out;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_start;
   logic             overrun;

   modport master (
      output clear, valid_in, data_in,
      input  sig_out, ser_out, ser_valid, ser_start, overrun
   );

   modport slave (
      input  clear, valid_in, data_in,
      output sig_out, ser_out, ser_valid, ser_start, overrun
   );
endinterface

// File: rtl/output_signature_sink.sv
// MISR sink that compresses a wide DUT output bus and periodically shifts the signature out serially.
// Define OUTPUT_SIGNATURE_PARITY_EN to append an even-parity bit to every serial frame.
module output_signature_sink #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] POLY        = WIDTH'(32'h04C11DB7),
   parameter logic [WIDTH-1:0] SEED        = WIDTH'(32'hFFFFFFFF),
   parameter int               DUMP_PERIOD = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   output_signature_sink_if.slave bus
);

   localparam int CNT_W = $clog2(DUMP_PERIOD);
   localparam int IDX_W = $clog2(WIDTH);

`ifdef OUTPUT_SIGNATURE_PARITY_EN
   typedef enum logic [1:0] {ACCUM, SHIFT, PARITY} state_t;
`else
   typedef enum logic {ACCUM, SHIFT} state_t;
`endif

   // Galois step; the register advances every cycle, data is folded only when valid.
   function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                  input logic             fold,
                                                  input logic [WIDTH-1:0] d);
      misr_step = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ (fold ? d : '0);
   endfunction

   logic [WIDTH-1:0] sig_q, sig_d;
   logic [WIDTH-1:0] shadow_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_dec;
   logic             snap_req;
   logic             sig_out_q;
   logic             ser_out_q;
   logic             ser_valid_q;
   logic             ser_start_q;
   logic             overrun_q;
   state_t           state_q;

   always_comb begin
      sig_d    = misr_step(sig_q, bus.valid_in, bus.data_in);
      snap_req = (cnt_q == CNT_W'(DUMP_PERIOD - 1));
      cnt_d    = snap_req ? '0 : cnt_q + CNT_W'(1);
      idx_dec  = idx_q - IDX_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sig_q     <= SEED;
         cnt_q     <= '0;
         sig_out_q <= ^SEED;
      end else if (bus.clear) begin
         sig_q     <= SEED;
         cnt_q     <= '0;
         sig_out_q <= ^sig_q;
      end else begin
         sig_q     <= sig_d;
         cnt_q     <= cnt_d;
         sig_out_q <= ^sig_q;
      end
   end

   // Snapshot includes this cycle's data; frozen for the whole frame.
   always_ff @(posedge clk) begin
      if (!bus.clear && snap_req && state_q == ACCUM) begin
         shadow_q <= sig_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ACCUM;
         idx_q       <= '0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_start_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (bus.clear) begin
         state_q     <= ACCUM;
         idx_q       <= '0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_start_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         ser_start_q <= 1'b0;
         if (snap_req && state_q != ACCUM) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            ACCUM: begin
               if (snap_req) begin
                  // Outputs are registered, so the first bit comes straight from sig_d.
                  state_q     <= SHIFT;
                  idx_q       <= IDX_W'(WIDTH - 1);
                  ser_out_q   <= sig_d[WIDTH-1];
                  ser_valid_q <= 1'b1;
                  ser_start_q <= 1'b1;
               end
            end
            SHIFT: begin
               if (idx_q == '0) begin
`ifdef OUTPUT_SIGNATURE_PARITY_EN
                  state_q   <= PARITY;
                  ser_out_q <= ^shadow_q;
`else
                  state_q     <= ACCUM;
                  ser_out_q   <= 1'b0;
                  ser_valid_q <= 1'b0;
`endif
               end else begin
                  idx_q     <= idx_dec;
                  ser_out_q <= shadow_q[idx_dec];
               end
            end
`ifdef OUTPUT_SIGNATURE_PARITY_EN
            PARITY: begin
               state_q     <= ACCUM;
               ser_out_q   <= 1'b0;
               ser_valid_q <= 1'b0;
            end
`endif
            default: state_q <= ACCUM;
         endcase
      end
   end

   assign bus.sig_out   = sig_out_q;
   assign bus.ser_out   = ser_out_q;
   assign bus.ser_valid = ser_valid_q;
   assign bus.ser_start = ser_start_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_output_signature_sink.sv
// Scoreboard bench for output_signature_sink (WIDTH=8, POLY=1D, SEED=01).
// A second instance with DUMP_PERIOD=6 exercises the overrun path.
module tb_output_signature_sink;

   localparam int               W    = 8;
   localparam int               P    = 16;
   localparam logic [W-1:0]     POLY = 8'h1D;
   localparam logic [W-1:0]     SEED = 8'h01;
`ifdef OUTPUT_SIGNATURE_PARITY_EN
   localparam int               FLEN = W + 1;
`else
   localparam int               FLEN = W;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   output_signature_sink_if #(.WIDTH(W)) bus ();
   output_signature_sink_if #(.WIDTH(W)) bus2 ();

   output_signature_sink #(.WIDTH(W), .POLY(POLY), .SEED(SEED), .DUMP_PERIOD(P)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   output_signature_sink #(.WIDTH(W), .POLY(POLY), .SEED(SEED), .DUMP_PERIOD(6)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2));

   int errors = 0;
   int checks = 0;

   logic [1:0]   sb[$];   // {start, bit} per expected frame cycle
   logic [W-1:0] m_sig;
   logic         m_sout;
   logic         m_ovr;
   int           m_cnt;
   int           m_left;

   function automatic logic [W-1:0] ref_step(input logic [W-1:0] s, input logic v,
                                             input logic [W-1:0] d);
      logic [W-1:0] r;
      r = s << 1;
      if (s[W-1]) r = r ^ POLY;
      if (v) r = r ^ d;
      return r;
   endfunction

   task automatic model_reset();
      m_sig  = SEED;
      m_sout = ^SEED;
      m_ovr  = 1'b0;
      m_cnt  = 0;
      m_left = 0;
      sb.delete();
   endtask

   task automatic step(input logic clr, input logic v, input logic [W-1:0] d);
      logic         busy;
      logic [W-1:0] nxt;
      bus.clear     = clr;
      bus.valid_in  = v;
      bus.data_in   = d;
      bus2.clear    = clr;
      bus2.valid_in = 1'b0;
      bus2.data_in  = '0;
      m_sout = ^m_sig;
      if (clr) begin
         m_sig  = SEED;
         m_cnt  = 0;
         m_left = 0;
         m_ovr  = 1'b0;
         sb.delete();
      end else begin
         busy = (m_left > 0);
         if (busy) m_left--;
         nxt = ref_step(m_sig, v, d);
         if (m_cnt == P - 1) begin
            if (busy) m_ovr = 1'b1;
            else begin
               sb.delete();
               for (int i = W - 1; i >= 0; i--) sb.push_back({(i == W - 1), nxt[i]});
`ifdef OUTPUT_SIGNATURE_PARITY_EN
               sb.push_back({1'b0, ^nxt});
`endif
               m_left = FLEN;
            end
         end
         m_sig = nxt;
         m_cnt = (m_cnt + 1) % P;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset         = 1'b0;
      bus.clear     = 1'b0;
      bus.valid_in  = 1'b0;
      bus.data_in   = '0;
      bus2.clear    = 1'b0;
      bus2.valid_in = 1'b0;
      bus2.data_in  = '0;
      @(posedge clk);
      #1;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.sig_out !== ^SEED) begin errors++; $display("FAIL reset_sig_out got=%b want=%b", bus.sig_out, ^SEED); end
      checks++; if ({bus.ser_out, bus.ser_valid, bus.ser_start, bus.overrun} !== 4'b0000) begin
         errors++; $display("FAIL reset_outputs got=%b want=0000", {bus.ser_out, bus.ser_valid, bus.ser_start, bus.overrun}); end
      checks++; if (dut.sig_q !== SEED) begin errors++; $display("FAIL reset_sig got=%h want=%h", dut.sig_q, SEED); end
      checks++; if (bus2.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun2 got=%b want=0", bus2.overrun); end
   endtask

   task automatic test_misr();
      logic [W-1:0] din[4];
      logic [W-1:0] exp_sig[4];
      logic         exp_so[4];
      din     = '{8'h00, 8'hFF, 8'h00, 8'h00};
      exp_sig = '{8'h02, 8'hFB, 8'hEB, 8'h00};
      exp_so  = '{1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, (i < 3), din[i]);
         if (i < 3) begin
            checks++; if (dut.sig_q !== exp_sig[i]) begin errors++; $display("FAIL misr_sig i=%0d got=%h want=%h", i, dut.sig_q, exp_sig[i]); end
         end
         checks++; if (bus.sig_out !== exp_so[i]) begin errors++; $display("FAIL misr_sig_out i=%0d got=%b want=%b", i, bus.sig_out, exp_so[i]); end
      end
   endtask

   task automatic test_frame();
      logic [1:0] e;
      int         nvalid = 0;
      do_reset();
      for (int c = 1; c <= 26; c++) begin
         step(1'b0, 1'b0, '0);
         checks++; if (bus.sig_out !== m_sout) begin errors++; $display("FAIL frame_sig_out c=%0d got=%b want=%b", c, bus.sig_out, m_sout); end
         checks++; if (bus.ser_valid !== (m_left > 0)) begin errors++; $display("FAIL frame_valid c=%0d got=%b want=%b", c, bus.ser_valid, (m_left > 0)); end
         if (m_left > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if ({bus.ser_start, bus.ser_out} !== e) begin errors++; $display("FAIL frame_bit c=%0d got=%b want=%b", c, {bus.ser_start, bus.ser_out}, e); end
         end
         if (bus.ser_valid === 1'b1) nvalid++;
         if (c == 16) begin
            checks++; if (bus.ser_start !== 1'b1) begin errors++; $display("FAIL frame_start16 got=%b want=1", bus.ser_start); end
         end
      end
      checks++; if (nvalid != FLEN) begin errors++; $display("FAIL frame_len got=%0d want=%0d", nvalid, FLEN); end
      checks++; if (bus.overrun !== m_ovr) begin errors++; $display("FAIL frame_overrun got=%b want=%b", bus.overrun, m_ovr); end
   endtask

   task automatic test_clear();
      logic [1:0] e;
      int         start_at = -1;
      do_reset();
      for (int c = 1; c <= 20; c++) begin
         step(1'b0, 1'b1, W'($urandom));
         checks++; if (bus.ser_valid !== (m_left > 0)) begin errors++; $display("FAIL clear_pre_valid c=%0d got=%b want=%b", c, bus.ser_valid, (m_left > 0)); end
         if (m_left > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if ({bus.ser_start, bus.ser_out} !== e) begin errors++; $display("FAIL clear_pre_bit c=%0d got=%b want=%b", c, {bus.ser_start, bus.ser_out}, e); end
         end
      end
      step(1'b1, 1'b1, 8'hA5);
      checks++; if (bus.ser_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got=%b want=0", bus.ser_valid); end
      checks++; if (dut.sig_q !== SEED) begin errors++; $display("FAIL clear_sig got=%h want=%h", dut.sig_q, SEED); end
      checks++; if (dut.cnt_q !== '0) begin errors++; $display("FAIL clear_cnt got=%0d want=0", dut.cnt_q); end
      for (int c = 1; c <= 40 && start_at < 0; c++) begin
         step(1'b0, 1'b0, '0);
         if (bus.ser_start === 1'b1) start_at = c;
         checks++; if (bus.ser_valid !== (m_left > 0)) begin errors++; $display("FAIL clear_post_valid c=%0d got=%b want=%b", c, bus.ser_valid, (m_left > 0)); end
         if (m_left > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if ({bus.ser_start, bus.ser_out} !== e) begin errors++; $display("FAIL clear_post_bit c=%0d got=%b want=%b", c, {bus.ser_start, bus.ser_out}, e); end
         end
      end
      checks++; if (start_at != 16) begin errors++; $display("FAIL clear_restart got=%0d want=16", start_at); end
   endtask

   task automatic test_async_reset();
      int start_at = -1;
      do_reset();
      for (int c = 1; c <= 18; c++) step(1'b0, 1'b1, W'($urandom));
      checks++; if (bus.ser_valid !== 1'b1) begin errors++; $display("FAIL areset_midframe got=%b want=1", bus.ser_valid); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if (bus.ser_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b want=0", bus.ser_valid); end
      checks++; if (dut.sig_q !== SEED) begin errors++; $display("FAIL areset_sig got=%h want=%h", dut.sig_q, SEED); end
      @(posedge clk);
      #1;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int c = 1; c <= 40 && start_at < 0; c++) begin
         step(1'b0, 1'b0, '0);
         if (bus.ser_start === 1'b1) start_at = c;
      end
      checks++; if (start_at != 16) begin errors++; $display("FAIL areset_restart got=%0d want=16", start_at); end
   endtask

   task automatic test_overrun();
      int nvalid = 0;
      do_reset();
      for (int c = 1; c <= 15; c++) begin
         step(1'b0, 1'b0, '0);
         if (bus2.ser_valid === 1'b1) nvalid++;
         if (c == 11) begin
            checks++; if (bus2.overrun !== 1'b0) begin errors++; $display("FAIL overrun_early got=%b want=0", bus2.overrun); end
         end
         if (c == 12) begin
            checks++; if (bus2.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b want=1", bus2.overrun); end
         end
      end
      checks++; if (nvalid != FLEN) begin errors++; $display("FAIL overrun_frame_len got=%0d want=%0d", nvalid, FLEN); end
      step(1'b1, 1'b0, '0);
      checks++; if (bus2.overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got=%b want=0", bus2.overrun); end
   endtask

   task automatic test_const_frame();
      logic [W-1:0] target;
      logic [W-1:0] d;
      target = 8'hEB;
      do_reset();
      for (int c = 1; c <= 15; c++) begin
         step(1'b0, 1'b0, '0);
         checks++; if (bus.ser_valid !== 1'b0) begin errors++; $display("FAIL const_idle c=%0d got=%b want=0", c, bus.ser_valid); end
      end
      d = target ^ ref_step(m_sig, 1'b0, '0);
      step(1'b0, 1'b1, d);
      for (int i = 0; i < FLEN; i++) begin
         checks++; if (bus.ser_valid !== 1'b1) begin errors++; $display("FAIL const_valid i=%0d got=%b want=1", i, bus.ser_valid); end
         if (i < W) begin
            checks++; if (bus.ser_out !== target[W-1-i]) begin errors++; $display("FAIL const_bit i=%0d got=%b want=%b", i, bus.ser_out, target[W-1-i]); end
         end else begin
            checks++; if (bus.ser_out !== 1'b0) begin errors++; $display("FAIL const_parity got=%b want=0", bus.ser_out); end
         end
         step(1'b0, 1'b0, '0);
      end
      checks++; if (bus.ser_valid !== 1'b0) begin errors++; $display("FAIL const_end got=%b want=0", bus.ser_valid); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_misr();
      test_frame();
      test_clear();
      test_async_reset();
      test_overrun();
      test_const_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
